ula_aritmetico_seq: RTL and testbench
=====================================

# ula_aritmetico_seq

Parametrised, sequential successor to the 6-bit combinational arithmetic ULA. It keeps the single-cycle add/sub/inc/dec/neg set and adds multi-cycle unsigned multiply, divide and remainder behind a Start/Busy/Done handshake. Results and flags are registered. The block sits between the operand register file and the result bus of the datapath.

## Interface
- WIDTH, 6: operand/result width in bits; legal range ≥ 2.
- Clk  in  1  system clock; rising edge active.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  operand A; captured on an accepted Start.
- B  in  WIDTH  operand B; captured on an accepted Start.
- Sel  in  4  operation code; captured on an accepted Start.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle pulse; O and the flags are updated in the same cycle.
- O  out  WIDTH  result; holds until the next Done.
- Overflow  out  1  overflow flag for the last operation.
- Zero  out  1  high when the last O equals 0.
- DivZero  out  1  high when the last DIV/REM had B = 0.

## Operation
- Sel 0000 ADD, A+B. Overflow = signed two's-complement overflow.
- Sel 0001 SUB, A−B. Overflow = signed overflow.
- Sel 0010 INC, A+1. Overflow = signed overflow, i.e. A = 2^(WIDTH−1)−1.
- Sel 0011 DEC, A−1. Overflow = signed overflow, i.e. A = −2^(WIDTH−1).
- Sel 0100 NEG, −A. Overflow set only when A = −2^(WIDTH−1); O then equals A.
- Sel 0101 MUL, unsigned. Shift-add over a 2·WIDTH accumulator, one B bit per cycle, LSB first.
  - O = low WIDTH bits of the product.
  - Overflow = OR of the high WIDTH bits.
- Sel 0110 DIV, unsigned quotient. Restoring division, one quotient bit per cycle, MSB first. Overflow = 0.
- Sel 0111 REM, unsigned remainder. Same datapath as DIV. Overflow = 0.
- Sel 1000–1111 are illegal. Result: O = 0, Overflow = 0, Zero = 1, DivZero = 0, single-cycle timing.
- DIV/REM with B = 0: no iteration, single-cycle timing, DivZero = 1, Overflow = 0.
  - DIV returns O = all ones.
  - REM returns O = A.
- DivZero = 0 for every other operation.
- FSM states:
  - IDLE: Start=1 → ITER if Sel is MUL, or DIV/REM with B≠0. Any other accepted Start → DONE.
  - ITER: counts WIDTH cycles, then → DONE.
  - DONE: Done=1, outputs updated, then → IDLE unconditionally.
- Start outside IDLE is ignored; it is not queued.
- A, B and Sel changes after acceptance have no effect on the running operation.
- Reset at any time: state → IDLE, any operation in progress is aborted with no Done, all outputs take their reset values.

## Timing
- Reset values: Busy=0, Done=0, O=0, Overflow=0, Zero=0, DivZero=0.
- Start accepted at edge n. Busy=1 from n+1 until the state returns to IDLE.
- Single-cycle ops (including illegal Sel and divide-by-zero): DONE at n+1. Done=1 and O/flags valid after edge n+1. Busy falls after n+2.
- MUL, and DIV/REM with B≠0: ITER for cycles n+1..n+WIDTH, then DONE at n+WIDTH+1.
- Done is high for exactly one cycle per accepted Start.
- Earliest next accepted Start is at the edge after DONE.
  - Single-cycle throughput: 1 op / 2 cycles.
  - Iterative throughput: 1 op / (WIDTH+2) cycles.
- Zero is computed from the new O, in the same cycle O updates.

## Test plan
All scenarios use WIDTH=6.
- ADD A=31, B=1 → Done at n+1; O=32; Overflow=1; Zero=0. SUB A=5, B=5 → O=0, Zero=1, Overflow=0.
- NEG A=32 → O=32, Overflow=1. INC A=63 → O=0, Zero=1, Overflow=0. Illegal Sel=1010 → O=0, Zero=1, Done at n+1.
- MUL A=9, B=7 → Done at n+7; O=63; Overflow=0; Busy high n+1..n+7. MUL A=9, B=8 → O=8, Overflow=1.
- DIV A=50, B=7 → O=7 at n+7. REM A=50, B=7 → O=1. DIV A=50, B=0 → O=63, DivZero=1, Done at n+1. REM A=50, B=0 → O=50, DivZero=1.
- MUL A=9, B=7 started, then a new Start with different A/B/Sel at n+3 → ignored; O=63 at n+7; Done pulses exactly once.
- MUL started, Reset pulsed at n+3 → Busy=0 and all outputs 0 immediately, no Done. Start ADD A=1, B=2 after Reset → O=3 at n'+1.

Source files
------------

// File: rtl/ula_aritmetico_seq.sv
// Sequential arithmetic unit: single-cycle add/sub/inc/dec/neg plus
// iterative unsigned multiply, divide and remainder behind a
// Start/Busy/Done handshake. Result and flags are registered and hold
// until the next Done.
module ula_aritmetico_seq #(
  parameter int WIDTH = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] O,
  output logic             Overflow,
  output logic             Zero,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_INC = 4'b0010;
  localparam logic [3:0] OP_DEC = 4'b0011;
  localparam logic [3:0] OP_NEG = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_REM = 4'b0111;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state;
  logic [3:0]       sel_r;
  logic [WIDTH-1:0] opnd_r;   // multiplicand for MUL, divisor for DIV/REM
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend-quotient shifter
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sc_o;
  logic             sc_ov;
  logic             sc_dz;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_r;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   it_hi;
  logic [WIDTH-1:0]   it_lo;
  logic [WIDTH-1:0]   fin_o;
  logic               fin_ov;

  assign Busy = (state != IDLE);

  // Single-cycle results straight from the inputs; DIV/REM entries are
  // only used for the divide-by-zero case, the B!=0 case iterates.
  always_comb begin
    sc_o  = '0;
    sc_ov = 1'b0;
    sc_dz = 1'b0;
    case (Sel)
      OP_ADD: begin
        sc_o  = A + B;
        sc_ov = (A[WIDTH-1] == B[WIDTH-1]) && (sc_o[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_o  = A - B;
        sc_ov = (A[WIDTH-1] != B[WIDTH-1]) && (sc_o[WIDTH-1] != A[WIDTH-1]);
      end
      OP_INC: begin
        sc_o  = A + ONE;
        sc_ov = (A == SMAX);
      end
      OP_DEC: begin
        sc_o  = A - ONE;
        sc_ov = (A == SMIN);
      end
      OP_NEG: begin
        sc_o  = (~A) + ONE;
        sc_ov = (A == SMIN);
      end
      OP_DIV: begin
        sc_o  = '1;
        sc_dz = 1'b1;
      end
      OP_REM: begin
        sc_o  = A;
        sc_dz = 1'b1;
      end
      default: begin
        sc_o  = '0;
        sc_ov = 1'b0;
        sc_dz = 1'b0;
      end
    endcase
  end

  // One iteration step: shift-add multiply (LSB first) or restoring
  // division (MSB first), sharing the acc_hi/acc_lo registers.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_r} : '0);
    mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_r};
    div_ge    = ~div_diff[WIDTH];
    div_r     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q     = {acc_lo[WIDTH-2:0], div_ge};
    if (sel_r == OP_MUL) begin
      it_hi  = mul_next[2*WIDTH-1:WIDTH];
      it_lo  = mul_next[WIDTH-1:0];
      fin_o  = mul_next[WIDTH-1:0];
      fin_ov = |mul_next[2*WIDTH-1:WIDTH];
    end else begin
      it_hi  = div_r;
      it_lo  = div_q;
      fin_o  = (sel_r == OP_REM) ? div_r : div_q;
      fin_ov = 1'b0;
    end
  end

  // Control FSM with registered result, flags and Done pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      sel_r    <= '0;
      opnd_r   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      Done     <= 1'b0;
      O        <= '0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            sel_r <= Sel;
            cnt   <= CW'(WIDTH - 1);
            if (Sel == OP_MUL) begin
              opnd_r <= A;
              acc_hi <= '0;
              acc_lo <= B;
              state  <= ITER;
            end else if ((Sel == OP_DIV || Sel == OP_REM) && B != '0) begin
              opnd_r <= B;
              acc_hi <= '0;
              acc_lo <= A;
              state  <= ITER;
            end else begin
              O        <= sc_o;
              Overflow <= sc_ov;
              Zero     <= (sc_o == '0);
              DivZero  <= sc_dz;
              Done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        ITER: begin
          acc_hi <= it_hi;
          acc_lo <= it_lo;
          if (cnt == '0) begin
            O        <= fin_o;
            Overflow <= fin_ov;
            Zero     <= (fin_o == '0);
            DivZero  <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_aritmetico_seq.sv
// Directed bench for ula_aritmetico_seq at WIDTH=6: vector table plus
// hand sequences for Start-while-busy and reset abort.
module tb_ula_aritmetico_seq;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [5:0] A;
  logic [5:0] B;
  logic [3:0] Sel;
  logic       Busy;
  logic       Done;
  logic [5:0] O;
  logic       Overflow;
  logic       Zero;
  logic       DivZero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sel;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] o;
    logic       ov;
    logic       z;
    logic       dz;
    int         lat;   // edges from accepting edge (counted as 1) to Done
  } vec_t;

  vec_t vecs[19];

  ula_aritmetico_seq #(.WIDTH(6)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Sel(Sel),
    .Busy(Busy), .Done(Done), .O(O), .Overflow(Overflow), .Zero(Zero),
    .DivZero(DivZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int   lat;
    logic busy_ok;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge Clk);
    A = v.a; B = v.b; Sel = v.sel; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; A = ~v.a; B = ~v.b; Sel = 4'b0101;
    lat = 1;
    busy_ok = Busy;
    while (!Done && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
      if (!Busy) busy_ok = 1'b0;
    end
    chk({p, " latency"}, lat, v.lat);
    chk({p, " busy"}, busy_ok, 1);
    chk({p, " O"}, O, v.o);
    chk({p, " Overflow"}, Overflow, v.ov);
    chk({p, " Zero"}, Zero, v.z);
    chk({p, " DivZero"}, DivZero, v.dz);
    @(posedge Clk); #1;
    chk({p, " Done clear"}, Done, 0);
    chk({p, " Busy clear"}, Busy, 0);
  endtask

  initial begin
    int   dn;
    int   dlat;
    logic [5:0] d_o;
    logic seen;
    //             sel      a      b      o    ov    z     dz   lat
    vecs[0]  = '{4'b0000, 6'd31, 6'd1,  6'd32, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'b0001, 6'd5,  6'd5,  6'd0,  1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'b0100, 6'd32, 6'd0,  6'd32, 1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'b0010, 6'd63, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'b1010, 6'd7,  6'd3,  6'd0,  1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{4'b0101, 6'd9,  6'd7,  6'd63, 1'b0, 1'b0, 1'b0, 7};
    vecs[6]  = '{4'b0101, 6'd9,  6'd8,  6'd8,  1'b1, 1'b0, 1'b0, 7};
    vecs[7]  = '{4'b0110, 6'd50, 6'd7,  6'd7,  1'b0, 1'b0, 1'b0, 7};
    vecs[8]  = '{4'b0111, 6'd50, 6'd7,  6'd1,  1'b0, 1'b0, 1'b0, 7};
    vecs[9]  = '{4'b0110, 6'd50, 6'd0,  6'd63, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{4'b0111, 6'd50, 6'd0,  6'd50, 1'b0, 1'b0, 1'b1, 1};
    vecs[11] = '{4'b0011, 6'd32, 6'd0,  6'd31, 1'b1, 1'b0, 1'b0, 1};
    vecs[12] = '{4'b0001, 6'd32, 6'd1,  6'd31, 1'b1, 1'b0, 1'b0, 1};
    vecs[13] = '{4'b0000, 6'd63, 6'd63, 6'd62, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{4'b0101, 6'd63, 6'd63, 6'd1,  1'b1, 1'b0, 1'b0, 7};
    vecs[15] = '{4'b0111, 6'd63, 6'd1,  6'd0,  1'b0, 1'b1, 1'b0, 7};
    vecs[16] = '{4'b0110, 6'd5,  6'd7,  6'd0,  1'b0, 1'b1, 1'b0, 7};
    vecs[17] = '{4'b0011, 6'd0,  6'd0,  6'd63, 1'b0, 1'b0, 1'b0, 1};
    vecs[18] = '{4'b0010, 6'd31, 6'd0,  6'd32, 1'b1, 1'b0, 1'b0, 1};

    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Sel = '0;
    #3;
    chk("reset Busy", Busy, 0);
    chk("reset Done", Done, 0);
    chk("reset O", O, 0);
    chk("reset flags", {Overflow, Zero, DivZero}, 0);
    @(negedge Clk); Reset = 1'b0;

    for (int i = 0; i < 19; i++) run_op(i, vecs[i]);

    // Start during a running MUL must be ignored, not queued.
    @(negedge Clk);
    A = 6'd9; B = 6'd7; Sel = 4'b0101; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    dn = Done ? 1 : 0; dlat = 1; d_o = O;
    for (int k = 2; k <= 16; k++) begin
      @(negedge Clk);
      if (k == 4) begin
        Start = 1'b1; A = 6'd1; B = 6'd2; Sel = 4'b0000;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk); #1;
      if (Done) begin dn++; dlat = k; d_o = O; end
    end
    chk("ignore done count", dn, 1);
    chk("ignore latency", dlat, 7);
    chk("ignore O", d_o, 63);
    chk("ignore not queued", Busy, 0);

    // Reset in the middle of a MUL aborts it with no Done.
    @(negedge Clk);
    A = 6'd9; B = 6'd7; Sel = 4'b0101; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort Busy", Busy, 0);
    chk("abort Done", Done, 0);
    chk("abort O", O, 0);
    chk("abort flags", {Overflow, Zero, DivZero}, 0);
    @(negedge Clk); Reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk); #1;
      if (Done || Busy) seen = 1'b1;
    end
    chk("abort no done", seen, 0);
    vecs[0] = '{4'b0000, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1};
    run_op(100, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
